cpu_cs_useq: RTL and testbench

//  Micro-program sequencer for the CPU control store. Each clock it computes the next
//  13-bit control-store address CSA_12_0 from the current microinstruction's next-address

---
 rtl/cpu_cs_pkg.sv | 37 +++
 rtl/cpu_cs_ustack.sv | 39 +++
 rtl/cpu_cs_useq.sv | 131 +++++++++++++
 tb/tb_cpu_cs_useq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_cs_pkg.sv
// Shared types for the control-store micro-sequencer: next-address commands,
// sequencer FSM states and the microstack request bundle.
package cpu_cs_pkg;

  localparam int CSA_W = 13;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    CMD_CONT  = 3'd0,
    CMD_JMP   = 3'd1,
    CMD_CALL  = 3'd2,
    CMD_RET   = 3'd3,
    CMD_MAP   = 3'd4,
    CMD_LOOP  = 3'd5,
    CMD_LDCNT = 3'd6,
    CMD_HOLD  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_RST_VEC = 2'd0,
    ST_RUN     = 2'd1,
    ST_STALLED = 2'd2,
    ST_TRAPPED = 2'd3
  } useq_state_e;

  typedef struct packed {
    logic             push;
    logic             pop;
    logic [CSA_W-1:0] data;
  } ustk_req_t;

  // Micro-PC increment; wraps at the top of the control store.
  function automatic logic [CSA_W-1:0] csa_inc(input logic [CSA_W-1:0] a);
    return a + CSA_W'(1);
  endfunction

endpackage

// File: rtl/cpu_cs_ustack.sv
// Microstack: STACK_DEPTH x CSA_W LIFO. Pushes when full and pops when empty are
// dropped here; the sequencer turns them into a stack error.
module cpu_cs_ustack
  import cpu_cs_pkg::*;
#(
  parameter  int STACK_DEPTH = 8,
  localparam int LVL_W       = $clog2(STACK_DEPTH + 1),
  localparam int AW          = $clog2(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  ustk_req_t        req,
  output logic [CSA_W-1:0] top,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [CSA_W-1:0] mem [STACK_DEPTH];
  logic [AW-1:0]    top_idx;

  assign full    = (level == LVL_W'(STACK_DEPTH));
  assign empty   = (level == '0);
  assign top_idx = AW'(level - LVL_W'(1));
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (req.push && !full) begin
      mem[level[AW-1:0]] <= req.data;
      level              <= level + LVL_W'(1);
    end else if (req.pop && !empty) begin
      level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/cpu_cs_useq.sv
// Control-store micro-sequencer: picks the next CSA from the command, condition,
// microstack, loop counter and trap input; STALL freezes everything.
module cpu_cs_useq
  import cpu_cs_pkg::*;
#(
  parameter int          STACK_DEPTH = 8,
  parameter logic [12:0] RESET_VEC   = 13'h0000,
  parameter logic [12:0] TRAP_VEC    = 13'h0010
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        TRAP,
  input  logic [2:0]  CMD,
  input  logic        COND,
  input  logic [12:0] JADDR,
  input  logic [12:0] MAPADDR,
  output logic [12:0] CSA_12_0,
  output logic        CSA_VLD,
  output logic        STK_ERR,
  output logic [3:0]  STK_LVL
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [CSA_W-1:0] upc, csa_nxt, stk_top;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stk_full, stk_empty, err_set, trap_evt;
  logic [LVL_W-1:0] stk_level;
  ustk_req_t        stk_req;
  useq_state_e      state;
  cmd_e             cmd;

  assign cmd      = cmd_e'(CMD);
  assign upc      = csa_inc(CSA_12_0);
  assign trap_evt = TRAP | err_set;

  cpu_cs_ustack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk   (CLK),
    .rst   (RESET),
    .req   (stk_req),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .level (stk_level)
  );

  // Next-address mux. A push into a full stack or a pop from an empty one
  // diverts to TRAP_VEC and leaves the stack untouched.
  always_comb begin
    csa_nxt = CSA_12_0;
    cnt_nxt = cnt;
    err_set = 1'b0;
    stk_req = '0;
    if (TRAP) begin
      csa_nxt      = TRAP_VEC;
      stk_req.data = CSA_12_0;
      if (stk_full) err_set      = 1'b1;
      else          stk_req.push = 1'b1;
    end else begin
      case (cmd)
        CMD_CONT: csa_nxt = upc;
        CMD_JMP:  csa_nxt = COND ? JADDR : upc;
        CMD_CALL: begin
          if (!COND) begin
            csa_nxt = upc;
          end else if (stk_full) begin
            csa_nxt = TRAP_VEC;
            err_set = 1'b1;
          end else begin
            csa_nxt      = JADDR;
            stk_req.push = 1'b1;
            stk_req.data = upc;
          end
        end
        CMD_RET: begin
          if (stk_empty) begin
            csa_nxt = TRAP_VEC;
            err_set = 1'b1;
          end else begin
            csa_nxt     = stk_top;
            stk_req.pop = 1'b1;
          end
        end
        CMD_MAP:  csa_nxt = MAPADDR;
        CMD_LOOP: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
            csa_nxt = JADDR;
          end else begin
            csa_nxt = upc;
          end
        end
        CMD_LDCNT: begin
          cnt_nxt = JADDR[CNT_W-1:0];
          csa_nxt = upc;
        end
        CMD_HOLD: csa_nxt = CSA_12_0;
        default:  csa_nxt = upc;
      endcase
    end
    if (STALL) begin
      stk_req = '0;
      err_set = 1'b0;
    end
  end

  // CSA_VLD is a decode of the registered state: low only while stalled.
  assign CSA_VLD = (state != ST_STALLED);
  assign STK_LVL = 4'(stk_level);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CSA_12_0 <= RESET_VEC;
      STK_ERR  <= 1'b0;
      cnt      <= '0;
      state    <= ST_RST_VEC;
    end else begin
      if (!STALL) begin
        CSA_12_0 <= csa_nxt;
        cnt      <= cnt_nxt;
        if (err_set) STK_ERR <= 1'b1;
      end
      case (state)
        ST_STALLED: state <= STALL ? ST_STALLED : (trap_evt ? ST_TRAPPED : ST_RUN);
        default:    state <= STALL ? ST_STALLED : (trap_evt ? ST_TRAPPED : ST_RUN);
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_cs_useq.sv
// Bench for cpu_cs_useq: directed vector table, hand-written reset sequences and
// randomized traffic against a queue-based reference model.
module tb_cpu_cs_useq;
  import cpu_cs_pkg::*;

  localparam logic [12:0] TRAP_V = 13'h0010;
  localparam int          DEPTH  = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0, STALL = 1'b0, TRAP = 1'b0, COND = 1'b0;
  logic [2:0]  CMD = 3'd0;
  logic [12:0] JADDR = '0, MAPADDR = '0;
  logic [12:0] CSA_12_0;
  logic        CSA_VLD, STK_ERR;
  logic [3:0]  STK_LVL;

  int n_chk = 0, n_pass = 0;

  always #5 CLK = ~CLK;

  cpu_cs_useq #(.STACK_DEPTH(DEPTH), .RESET_VEC(13'h0000), .TRAP_VEC(TRAP_V)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .TRAP(TRAP), .CMD(CMD), .COND(COND),
    .JADDR(JADDR), .MAPADDR(MAPADDR), .CSA_12_0(CSA_12_0), .CSA_VLD(CSA_VLD),
    .STK_ERR(STK_ERR), .STK_LVL(STK_LVL)
  );

  // Reference model: address, counter, sticky error and a queue as the stack.
  logic [12:0] m_csa;
  logic [7:0]  m_cnt;
  logic        m_err, m_vld;
  logic [12:0] m_stk[$];

  task automatic model_reset();
    m_csa = 13'h0000; m_cnt = 8'd0; m_err = 1'b0; m_vld = 1'b1;
    m_stk.delete();
  endtask

  task automatic m_push(input logic [12:0] ret_addr, input logic [12:0] target);
    if (m_stk.size() >= DEPTH) begin
      m_err = 1'b1; m_csa = TRAP_V;
    end else begin
      m_stk.push_back(ret_addr); m_csa = target;
    end
  endtask

  task automatic model_step(input logic st, input logic tr, input logic [2:0] c,
                            input logic cd, input logic [12:0] ja, input logic [12:0] ma);
    logic [12:0] upc;
    upc   = 13'((32'(m_csa) + 1) % 8192);
    m_vld = !st;
    if (!st) begin
      if (tr) m_push(m_csa, TRAP_V);
      else begin
        case (c)
          3'd0: m_csa = upc;
          3'd1: m_csa = cd ? ja : upc;
          3'd2: if (cd) m_push(upc, ja); else m_csa = upc;
          3'd3: if (m_stk.size() == 0) begin m_err = 1'b1; m_csa = TRAP_V; end
                else m_csa = m_stk.pop_back();
          3'd4: m_csa = ma;
          3'd5: if (m_cnt != 0) begin m_cnt = m_cnt - 8'd1; m_csa = ja; end
                else m_csa = upc;
          3'd6: begin m_cnt = ja[7:0]; m_csa = upc; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic cyc(input logic st, input logic tr, input logic [2:0] c,
                     input logic cd, input logic [12:0] ja, input logic [12:0] ma);
    STALL = st; TRAP = tr; CMD = c; COND = cd; JADDR = ja; MAPADDR = ma;
    @(posedge CLK); #1;
    model_step(st, tr, c, cd, ja, ma);
  endtask

  task automatic chk_model(input int idx);
    chk("rnd_csa", idx, 32'(CSA_12_0), 32'(m_csa));
    chk("rnd_vld", idx, 32'(CSA_VLD),  32'(m_vld));
    chk("rnd_err", idx, 32'(STK_ERR),  32'(m_err));
    chk("rnd_lvl", idx, 32'(STK_LVL),  32'(m_stk.size()));
  endtask

  task automatic do_reset();
    RESET = 1'b1; STALL = 1'b0; TRAP = 1'b0; CMD = 3'd0;
    model_reset();
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  typedef struct {
    string       tag;
    logic        st, tr;
    logic [2:0]  c;
    logic        cd;
    logic [12:0] ja, ma, csa;
    logic [3:0]  lvl;
    logic        err, vld;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input string tag, input logic st, input logic tr, input logic [2:0] c,
                     input logic cd, input logic [12:0] ja, input logic [12:0] ma,
                     input logic [12:0] csa, input logic [3:0] lvl, input logic err, input logic vld);
    vec_t v;
    v.tag = tag; v.st = st; v.tr = tr; v.c = c; v.cd = cd; v.ja = ja; v.ma = ma;
    v.csa = csa; v.lvl = lvl; v.err = err; v.vld = vld;
    vecs.push_back(v);
  endtask

  logic        r_st, r_tr, r_cd;
  logic [2:0]  r_c;
  logic [12:0] r_ja, r_ma;

  initial begin
    // Sequential walk, wrap and jumps
    for (int i = 1; i <= 4; i++) add("cont", 0, 0, CMD_CONT, 0, 0, 0, 13'(i), 0, 0, 1);
    add("jmp_top", 0, 0, CMD_JMP,  1, 13'h1FFF, 0, 13'h1FFF, 0, 0, 1);
    add("wrap",    0, 0, CMD_CONT, 0, 0,        0, 13'h0000, 0, 0, 1);
    add("jmp_nt",  0, 0, CMD_JMP,  0, 13'h0400, 0, 13'h0001, 0, 0, 1);
    add("jmp_t",   0, 0, CMD_JMP,  1, 13'h0400, 0, 13'h0400, 0, 0, 1);
    // Call/return
    add("jmp",     0, 0, CMD_JMP,  1, 13'h0100, 0, 13'h0100, 0, 0, 1);
    add("call",    0, 0, CMD_CALL, 1, 13'h0200, 0, 13'h0200, 1, 0, 1);
    add("ret",     0, 0, CMD_RET,  0, 0,        0, 13'h0101, 0, 0, 1);
    add("call_nt", 0, 0, CMD_CALL, 0, 13'h0300, 0, 13'h0102, 0, 0, 1);
    // Loop counter (upper JADDR bits must not reach the counter), with a stall inside
    add("ldcnt",   0, 0, CMD_LDCNT, 0, 13'h1F03, 0, 13'h0103, 0, 0, 1);
    add("loop1",   0, 0, CMD_LOOP,  0, 13'h0050, 0, 13'h0050, 0, 0, 1);
    add("loop2",   0, 0, CMD_LOOP,  0, 13'h0050, 0, 13'h0050, 0, 0, 1);
    add("stall",   1, 0, CMD_LOOP,  0, 13'h0050, 0, 13'h0050, 0, 0, 0);
    add("loop3",   0, 0, CMD_LOOP,  0, 13'h0050, 0, 13'h0050, 0, 0, 1);
    add("loop_ex", 0, 0, CMD_LOOP,  0, 13'h0050, 0, 13'h0051, 0, 0, 1);
    add("map",     0, 0, CMD_MAP,   0, 0, 13'h0AAA, 13'h0AAA, 0, 0, 1);
    add("hold",    0, 0, CMD_HOLD,  1, 13'h0555, 0, 13'h0AAA, 0, 0, 1);
    // Trap: stall beats trap, then trap pushes the interrupted address
    add("jmp",     0, 0, CMD_JMP,  1, 13'h0123, 0, 13'h0123, 0, 0, 1);
    add("st_trap", 1, 1, CMD_JMP,  1, 13'h0400, 0, 13'h0123, 0, 0, 0);
    add("trap",    0, 1, CMD_JMP,  1, 13'h0400, 0, TRAP_V,   1, 0, 1);
    add("trap_rt", 0, 0, CMD_RET,  0, 0,        0, 13'h0123, 0, 0, 1);
    // Overflow on the 9th nested call, then drain and underflow
    add("call1",   0, 0, CMD_CALL, 1, 13'h0200, 0, 13'h0200, 1, 0, 1);
    for (int i = 2; i <= 8; i++) add("calln", 0, 0, CMD_CALL, 1, 13'h0200, 0, 13'h0200, 4'(i), 0, 1);
    add("ovf",     0, 0, CMD_CALL, 1, 13'h0200, 0, TRAP_V,   8, 1, 1);
    for (int i = 7; i >= 1; i--) add("ret_n", 0, 0, CMD_RET, 0, 0, 0, 13'h0201, 4'(i), 1, 1);
    add("ret_l",   0, 0, CMD_RET,  0, 0,        0, 13'h0124, 0, 1, 1);
    add("unf",     0, 0, CMD_RET,  0, 0,        0, TRAP_V,   0, 1, 1);

    // Reset state
    #2 RESET = 1'b1;
    model_reset();
    #10;
    chk("rst_csa", 0, 32'(CSA_12_0), 32'h0000);
    chk("rst_vld", 0, 32'(CSA_VLD),  32'h1);
    chk("rst_err", 0, 32'(STK_ERR),  32'h0);
    chk("rst_lvl", 0, 32'(STK_LVL),  32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].st, vecs[i].tr, vecs[i].c, vecs[i].cd, vecs[i].ja, vecs[i].ma);
      chk({vecs[i].tag, "_csa"}, i, 32'(CSA_12_0), 32'(vecs[i].csa));
      chk({vecs[i].tag, "_lvl"}, i, 32'(STK_LVL),  32'(vecs[i].lvl));
      chk({vecs[i].tag, "_err"}, i, 32'(STK_ERR),  32'(vecs[i].err));
      chk({vecs[i].tag, "_vld"}, i, 32'(CSA_VLD),  32'(vecs[i].vld));
    end

    // Asynchronous reset while stalled with the error flag set
    cyc(1, 0, CMD_CONT, 0, 0, 0);
    #2 RESET = 1'b1;
    #1;
    model_reset();
    chk("rst_stall_csa", 0, 32'(CSA_12_0), 32'h0000);
    chk("rst_stall_vld", 0, 32'(CSA_VLD),  32'h1);
    chk("rst_stall_err", 0, 32'(STK_ERR),  32'h0);
    chk("rst_stall_lvl", 0, 32'(STK_LVL),  32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    cyc(0, 0, CMD_CONT, 0, 0, 0);
    chk("post_rst_csa", 0, 32'(CSA_12_0), 32'h0001);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if (k % 400 == 399) do_reset();
      r_st = ($urandom_range(0, 9) == 0);
      r_tr = ($urandom_range(0, 31) == 0);
      r_c  = 3'($urandom_range(0, 7));
      r_cd = ($urandom_range(0, 3) != 0);
      r_ja = 13'($urandom);
      r_ma = 13'($urandom);
      if (r_c == CMD_LDCNT && $urandom_range(0, 1) == 1) r_ja[7:0] = 8'($urandom_range(0, 4));
      cyc(r_st, r_tr, r_c, r_cd, r_ja, r_ma);
      chk_model(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
